// File: rtl/health_bar_trail.sv
// One player's health bar with a delayed damage trail, low-health fill blink and optional mirroring.
// Latency: oled_colour/draw registered 1 cycle after pixel_index; no backpressure (free-running pixel scan and tick strobe).
module health_bar_trail #(
  parameter int FULL_HEALTH = 200,
  parameter int X_START     = 55,
  parameter int Y_START     = 2,
  parameter int BAR_LEN     = 40,
  parameter int BAR_HEIGHT  = 8,
  parameter int MIRROR      = 0,
  parameter int DRAIN_DELAY = 30,
  parameter int LOW_HEALTH  = 40,
  parameter int BLINK_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [8:0]  curr_health,
  input  logic [12:0] pixel_index,
  output logic [15:0] oled_colour,
  output logic        draw,
  output logic [8:0]  trail_health,
  output logic        ko
);

  localparam logic [8:0]  FULL_H     = 9'(FULL_HEALTH);
  localparam logic [8:0]  LOW_H      = 9'(LOW_HEALTH);
  localparam logic [15:0] DELAY      = 16'(DRAIN_DELAY);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [15:0] INNER      = 16'(BAR_LEN - 2);
  localparam logic [15:0] FULL_W     = 16'(FULL_HEALTH);
  localparam logic [15:0] X_L        = 16'(X_START);
  localparam logic [15:0] X_R        = 16'(X_START + BAR_LEN - 1);
  localparam logic [15:0] X_IL       = 16'(X_START + 1);
  localparam logic [15:0] X_IR       = 16'(X_START + BAR_LEN - 2);
  localparam logic [15:0] Y_T        = 16'(Y_START);
  localparam logic [15:0] Y_B        = 16'(Y_START + BAR_HEIGHT - 1);
  localparam logic [15:0] Y_IT       = 16'(Y_START + 1);
  localparam logic [15:0] Y_IB       = 16'(Y_START + BAR_HEIGHT - 2);

  localparam logic [15:0] COL_YELLOW = 16'hFFE0;
  localparam logic [15:0] COL_ORANGE = 16'hFC00;
  localparam logic [15:0] COL_RED    = 16'hF800;
  localparam logic [15:0] COL_WHITE  = 16'hFFFF;
  localparam logic [15:0] COL_BLACK  = 16'h0000;

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [8:0]  h, prev_h, trail_nxt;
  logic [15:0] hold_cnt, hold_nxt;
  logic [15:0] blink_cnt;
  logic        blink_phase, low;
  logic [15:0] px_x, px_y, col_k, fill_len, trail_len, fill_colour, colour_nxt;
  logic        in_box, in_inner;

  assign h   = (curr_health > FULL_H) ? FULL_H : curr_health;
  assign low = (h != 9'd0) && (h <= LOW_H);

  // A heal overrides everything: trail snaps up and any pending drain is cancelled.
  always_comb begin
    state_nxt = state;
    trail_nxt = trail_health;
    hold_nxt  = hold_cnt;
    if (h > trail_health) begin
      trail_nxt = h;
      state_nxt = IDLE;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (h < trail_health) begin
            state_nxt = HOLD;
            hold_nxt  = DELAY;
          end
        end
        HOLD: begin
          if (h < prev_h) begin
            hold_nxt = DELAY;
          end else if (tick) begin
            if (hold_cnt <= 16'd1) begin
              state_nxt = DRAIN;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_cnt - 16'd1;
            end
          end
        end
        DRAIN: begin
          if (h < prev_h) begin
            state_nxt = HOLD;
            hold_nxt  = DELAY;
          end else if (trail_health == h) begin
            state_nxt = IDLE;
          end else if (tick) begin
            trail_nxt = trail_health - 9'd1;
            if (trail_nxt == h) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      trail_health <= FULL_H;
      hold_cnt     <= '0;
      prev_h       <= FULL_H;
      ko           <= 1'b0;
    end else begin
      state        <= state_nxt;
      trail_health <= trail_nxt;
      hold_cnt     <= hold_nxt;
      prev_h       <= h;
      ko           <= (trail_health == 9'd0) && (state == IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!low) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // col_k counts inner columns from the anchored edge of the fill.
  always_comb begin
    px_x        = 16'(pixel_index % 13'd96);
    px_y        = 16'(pixel_index / 13'd96);
    in_box      = (px_x >= X_L) && (px_x <= X_R) && (px_y >= Y_T) && (px_y <= Y_B);
    in_inner    = (px_x >= X_IL) && (px_x <= X_IR) && (px_y >= Y_IT) && (px_y <= Y_IB);
    col_k       = (MIRROR != 0) ? (X_IR - px_x) : (px_x - X_IL);
    fill_len    = (16'(h) * INNER) / FULL_W;
    trail_len   = (16'(trail_health) * INNER) / FULL_W;
    fill_colour = (low && blink_phase) ? COL_ORANGE : COL_YELLOW;
    colour_nxt  = COL_BLACK;
    if (in_inner) begin
      if (col_k < fill_len)       colour_nxt = fill_colour;
      else if (col_k < trail_len) colour_nxt = COL_RED;
      else                        colour_nxt = COL_BLACK;
    end else if (in_box) begin
      colour_nxt = COL_WHITE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_colour <= '0;
      draw        <= 1'b0;
    end else begin
      oled_colour <= colour_nxt;
      draw        <= in_box;
    end
  end

endmodule

// File: tb/tb_health_bar_trail.sv
// Bench for health_bar_trail: directed scenarios plus randomized stimulus against a tick-count reference model.
module tb_health_bar_trail;

  localparam int FULL  = 200;
  localparam int INNER = 38;
  localparam int DELAY = 30;

  logic        health_drop_clk = 1'b0;
  logic        reset, tick;
  logic [8:0]  curr_health;
  logic [12:0] pixel_index;
  logic [15:0] oled_colour, oled_colour_m;
  logic        draw, draw_m, ko, ko_m;
  logic [8:0]  trail_health, trail_health_m;

  always #5 health_drop_clk = ~health_drop_clk;

  health_bar_trail #(.MIRROR(0)) dut (
    .clk(health_drop_clk), .reset(reset), .tick(tick), .curr_health(curr_health),
    .pixel_index(pixel_index), .oled_colour(oled_colour), .draw(draw),
    .trail_health(trail_health), .ko(ko)
  );

  health_bar_trail #(.MIRROR(1)) dut_m (
    .clk(health_drop_clk), .reset(reset), .tick(tick), .curr_health(curr_health),
    .pixel_index(pixel_index), .oled_colour(oled_colour_m), .draw(draw_m),
    .trail_health(trail_health_m), .ko(ko_m)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: trail plus "ticks since most recent hit" and "ticks spent at low health".
  int m_trail, m_prev_h, m_since, m_lowticks;
  bit m_active;
  logic [15:0] e_col, e_col_m;
  bit e_draw, e_ko;

  function automatic int clamp_h(input int c);
    return (c > FULL) ? FULL : c;
  endfunction

  function automatic bit ref_draw(input int pix);
    int x, y;
    x = pix % 96;
    y = pix / 96;
    return (x >= 55) && (x <= 94) && (y >= 2) && (y <= 9);
  endfunction

  function automatic logic [15:0] ref_colour(input int pix, input int hh, input int tr,
                                             input int lowticks, input bit mir);
    int x, y, k, fill, tlen;
    bit inner, low, phase;
    x     = pix % 96;
    y     = pix / 96;
    inner = (x >= 56) && (x <= 93) && (y >= 3) && (y <= 8);
    k     = mir ? (93 - x) : (x - 56);
    fill  = hh * INNER / FULL;
    tlen  = tr * INNER / FULL;
    low   = (hh > 0) && (hh <= 40);
    phase = ((lowticks / 8) % 2) == 1;
    if (inner) begin
      if (k < fill) return (low && phase) ? 16'hFC00 : 16'hFFE0;
      if (k < tlen) return 16'hF800;
      return 16'h0000;
    end
    if (ref_draw(pix)) return 16'hFFFF;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_trail = FULL; m_prev_h = FULL; m_since = 0; m_lowticks = 0; m_active = 0;
    e_col = 16'h0000; e_col_m = 16'h0000; e_draw = 0; e_ko = 0;
  endtask

  // Predict registered outputs from the pre-edge state, advance the model, then clock.
  task automatic cycle();
    int hh;
    hh      = clamp_h(int'(curr_health));
    e_col   = ref_colour(int'(pixel_index), hh, m_trail, m_lowticks, 1'b0);
    e_col_m = ref_colour(int'(pixel_index), hh, m_trail, m_lowticks, 1'b1);
    e_draw  = ref_draw(int'(pixel_index));
    e_ko    = (m_trail == 0);
    if (hh > m_trail) begin
      m_trail  = hh;
      m_active = 0;
    end else begin
      if ((!m_active && hh < m_trail) || (m_active && hh < m_prev_h)) begin
        m_active = 1;
        m_since  = 0;
      end else if (m_active && tick) begin
        m_since++;
        if (m_since > DELAY && m_trail > hh) m_trail--;
      end
      if (m_active && m_since >= DELAY && m_trail == hh) m_active = 0;
    end
    if (!((hh > 0) && (hh <= 40))) m_lowticks = 0;
    else if (tick) m_lowticks++;
    m_prev_h = hh;
    @(posedge health_drop_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; curr_health = 9'd200; pixel_index = 13'd344;
    #2;
    model_reset();
    vectors++; if (trail_health !== 9'd200) begin miscompares++; $display("FAIL reset_trail: got %0d want 200", trail_health); end
    vectors++; if (ko !== 1'b0) begin miscompares++; $display("FAIL reset_ko: got %b want 0", ko); end
    vectors++; if (oled_colour !== 16'h0000) begin miscompares++; $display("FAIL reset_colour: got %h want 0000", oled_colour); end
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL reset_draw: got %b want 0", draw); end
    @(negedge health_drop_clk);
    reset = 1'b0;
  endtask

  task automatic test_full_bar();
    curr_health = 9'd200; pixel_index = 13'd344;
    cycle();
    vectors++; if (oled_colour !== 16'hFFE0) begin miscompares++; $display("FAIL full_fill: got %h want ffe0", oled_colour); end
    vectors++; if (draw !== 1'b1) begin miscompares++; $display("FAIL full_draw: got %b want 1", draw); end
    pixel_index = 13'd0;
    cycle();
    vectors++; if (oled_colour !== 16'h0000) begin miscompares++; $display("FAIL outside_colour: got %h want 0000", oled_colour); end
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL outside_draw: got %b want 0", draw); end
  endtask

  task automatic test_drain_timing();
    tick = 1'b1; curr_health = 9'd150; pixel_index = 13'd459;
    cycle();
    for (int i = 1; i <= 85; i++) begin
      cycle();
      vectors++;
      if (trail_health !== 9'(m_trail)) begin miscompares++; $display("FAIL drain_model i=%0d: got %0d want %0d", i, trail_health, m_trail); end
      if (i == 30) begin vectors++; if (trail_health !== 9'd200) begin miscompares++; $display("FAIL hold_end: got %0d want 200", trail_health); end end
      if (i == 31) begin vectors++; if (trail_health !== 9'd199) begin miscompares++; $display("FAIL drain_start: got %0d want 199", trail_health); end end
      if (i == 80) begin vectors++; if (trail_health !== 9'd150) begin miscompares++; $display("FAIL drain_end: got %0d want 150", trail_health); end end
    end
    vectors++; if (trail_health !== 9'd150) begin miscompares++; $display("FAIL drain_settled: got %0d want 150", trail_health); end
  endtask

  task automatic test_heal_mid_drain();
    tick = 1'b1; curr_health = 9'd200;
    cycle();
    curr_health = 9'd150;
    cycle();
    for (int i = 0; i < 60; i++) cycle();
    vectors++; if (trail_health !== 9'd170) begin miscompares++; $display("FAIL mid_drain: got %0d want 170", trail_health); end
    curr_health = 9'd180;
    cycle();
    vectors++; if (trail_health !== 9'd180) begin miscompares++; $display("FAIL heal_snap: got %0d want 180", trail_health); end
    for (int i = 0; i < 40; i++) cycle();
    vectors++; if (trail_health !== 9'd180) begin miscompares++; $display("FAIL heal_no_drain: got %0d want 180", trail_health); end
  endtask

  task automatic test_geometry();
    tick = 1'b1; curr_health = 9'd200;
    cycle();
    curr_health = 9'd100;
    cycle();
    pixel_index = 13'd459;
    cycle();
    vectors++; if (oled_colour !== 16'hF800) begin miscompares++; $display("FAIL trail_pixel: got %h want f800", oled_colour); end
    pixel_index = 13'd458;
    cycle();
    vectors++; if (oled_colour !== 16'hFFE0) begin miscompares++; $display("FAIL last_fill_pixel: got %h want ffe0", oled_colour); end
    pixel_index = 13'd439;
    cycle();
    vectors++; if (oled_colour !== 16'hFFFF) begin miscompares++; $display("FAIL border_pixel: got %h want ffff", oled_colour); end
  endtask

  task automatic test_mirror();
    tick = 1'b1; curr_health = 9'd100;
    for (int i = 0; i < 140; i++) cycle();
    pixel_index = 13'd477;
    cycle();
    vectors++; if (oled_colour_m !== 16'hFFE0) begin miscompares++; $display("FAIL mirror_fill: got %h want ffe0", oled_colour_m); end
    vectors++; if (oled_colour !== 16'h0000) begin miscompares++; $display("FAIL unmirrored_far: got %h want 0000", oled_colour); end
    pixel_index = 13'd440;
    cycle();
    vectors++; if (oled_colour_m !== 16'h0000) begin miscompares++; $display("FAIL mirror_empty: got %h want 0000", oled_colour_m); end
    vectors++; if (trail_health_m !== 9'd100) begin miscompares++; $display("FAIL mirror_trail: got %0d want 100", trail_health_m); end
  endtask

  task automatic test_blink();
    int orange;
    orange = 0;
    tick = 1'b1; curr_health = 9'd30; pixel_index = 13'd344;
    for (int i = 0; i < 120; i++) cycle();
    for (int i = 0; i < 32; i++) begin
      cycle();
      vectors++;
      if (oled_colour !== e_col) begin miscompares++; $display("FAIL blink_model i=%0d: got %h want %h", i, oled_colour, e_col); end
      if (oled_colour === 16'hFC00) orange++;
    end
    vectors++; if (orange != 16) begin miscompares++; $display("FAIL blink_duty: got %0d orange want 16", orange); end
  endtask

  task automatic test_ko_and_reset();
    tick = 1'b1; curr_health = 9'd0; pixel_index = 13'd344;
    for (int i = 0; i < 70; i++) cycle();
    vectors++; if (ko !== 1'b1) begin miscompares++; $display("FAIL ko_set: got %b want 1", ko); end
    vectors++; if (trail_health !== 9'd0) begin miscompares++; $display("FAIL ko_trail: got %0d want 0", trail_health); end
    for (int i = 0; i < 16; i++) begin
      cycle();
      vectors++; if (oled_colour !== 16'h0000) begin miscompares++; $display("FAIL ko_no_blink i=%0d: got %h want 0000", i, oled_colour); end
    end
    curr_health = 9'd100;
    cycle();
    cycle();
    vectors++; if (ko !== 1'b0) begin miscompares++; $display("FAIL ko_clear: got %b want 0", ko); end
    curr_health = 9'd50;
    for (int i = 0; i < 6; i++) cycle();
    reset = 1'b1;
    #1;
    vectors++; if (trail_health !== 9'd200) begin miscompares++; $display("FAIL midhold_reset_trail: got %0d want 200", trail_health); end
    vectors++; if (ko !== 1'b0) begin miscompares++; $display("FAIL midhold_reset_ko: got %b want 0", ko); end
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL midhold_reset_draw: got %b want 0", draw); end
    model_reset();
    @(negedge health_drop_clk);
    reset = 1'b0;
    cycle();
    for (int i = 1; i <= 31; i++) begin
      cycle();
      if (i == 30) begin vectors++; if (trail_health !== 9'd200) begin miscompares++; $display("FAIL rehold_end: got %0d want 200", trail_health); end end
      if (i == 31) begin vectors++; if (trail_health !== 9'd199) begin miscompares++; $display("FAIL rehold_drain: got %0d want 199", trail_health); end end
    end
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        c = int'(curr_health);
        case ($urandom_range(0, 3))
          0: c = int'($urandom_range(0, 511));
          1: c = (c > 10) ? c - int'($urandom_range(1, 10)) : 0;
          2: c = c + int'($urandom_range(1, 20));
          default: c = int'($urandom_range(0, 200));
        endcase
        if (c > 511) c = 511;
        curr_health = 9'(c);
      end
      tick = ($urandom_range(0, 2) == 0);
      pixel_index = 13'(int'($urandom_range(0, 11)) * 96 + int'($urandom_range(50, 100)));
      cycle();
      vectors++; if (trail_health !== 9'(m_trail)) begin miscompares++; $display("FAIL rand_trail n=%0d: got %0d want %0d", n, trail_health, m_trail); end
      vectors++; if (trail_health_m !== 9'(m_trail)) begin miscompares++; $display("FAIL rand_trail_m n=%0d: got %0d want %0d", n, trail_health_m, m_trail); end
      vectors++; if (ko !== e_ko) begin miscompares++; $display("FAIL rand_ko n=%0d: got %b want %b", n, ko, e_ko); end
      vectors++; if (oled_colour !== e_col) begin miscompares++; $display("FAIL rand_colour n=%0d: got %h want %h", n, oled_colour, e_col); end
      vectors++; if (oled_colour_m !== e_col_m) begin miscompares++; $display("FAIL rand_colour_m n=%0d: got %h want %h", n, oled_colour_m, e_col_m); end
      vectors++; if (draw !== e_draw || draw_m !== e_draw) begin miscompares++; $display("FAIL rand_draw n=%0d: got %b/%b want %b", n, draw, draw_m, e_draw); end
    end
  endtask

  initial begin
    test_reset();
    test_full_bar();
    test_drain_timing();
    test_heal_mid_drain();
    test_geometry();
    test_mirror();
    test_blink();
    test_ko_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
